// File: rtl/md_seq_unit.sv
// Iterative radix-2 multiply/divide sequencer: shift-add multiply and restoring divide,
// one step per cycle, with a sign fixup and half/quotient/remainder selection at the end.
module md_seq_unit #(
  parameter int WIDTH     = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state, w_state_next;
  logic               r_is_div, w_is_div_next;
  logic               r_hi, w_hi_next;
  logic               r_sign_a, w_sign_a_next;
  logic               r_sign_b, w_sign_b_next;
  logic               r_bzero, w_bzero_next;
  logic [WIDTH-1:0]   r_a_raw, w_a_raw_next;
  logic [WIDTH-1:0]   r_mag_b, w_mag_b_next;
  logic [2*WIDTH-1:0] r_acc, w_acc_next;
  logic [CW-1:0]      r_cnt, w_cnt_next;
  logic [WIDTH-1:0]   r_result, w_result_next;
  logic               r_done, w_done_next;
  logic               r_div_zero, w_div_zero_next;

  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_addend;
  logic [WIDTH:0]     w_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_mul_step, w_div_step, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_fix_result;

  // Magnitudes: negating the most negative value leaves its bit pattern, which is the right unsigned magnitude.
  assign w_a_neg = ~op[1] & a[WIDTH-1];
  assign w_b_neg = ~op[1] & b[WIDTH-1];
  assign w_mag_a = w_a_neg ? -a : a;
  assign w_mag_b = w_b_neg ? -b : b;

  // Multiply: low half holds the multiplier and is shifted out as product bits enter from the top.
  assign w_addend   = r_acc[0] ? r_mag_b : '0;
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_step = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_mag_b};
  assign w_div_step = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
  assign w_quo  = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_result = '0;
    if (!r_is_div)
      w_fix_result = r_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
    else if (r_bzero)
      w_fix_result = r_hi ? r_a_raw : '1;
    else
      w_fix_result = r_hi ? w_rem : w_quo;
  end

  always_comb begin
    w_state_next    = r_state;
    w_is_div_next   = r_is_div;
    w_hi_next       = r_hi;
    w_sign_a_next   = r_sign_a;
    w_sign_b_next   = r_sign_b;
    w_bzero_next    = r_bzero;
    w_a_raw_next    = r_a_raw;
    w_mag_b_next    = r_mag_b;
    w_acc_next      = r_acc;
    w_cnt_next      = r_cnt;
    w_result_next   = r_result;
    w_done_next     = 1'b0;
    w_div_zero_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_is_div_next = op[2];
          w_hi_next     = op[0];
          w_sign_a_next = w_a_neg;
          w_sign_b_next = w_b_neg;
          w_bzero_next  = (b == '0);
          w_a_raw_next  = a;
          w_mag_b_next  = w_mag_b;
          w_acc_next    = {{WIDTH{1'b0}}, w_mag_a};
          w_cnt_next    = '0;
          w_state_next  = (FAST_ZERO && op[2] && (b == '0)) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          w_state_next = S_IDLE;
        end else begin
          w_acc_next = r_is_div ? w_div_step : w_mul_step;
          w_cnt_next = r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1))
            w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        w_state_next = S_IDLE;
        if (!flush) begin
          w_result_next   = w_fix_result;
          w_done_next     = 1'b1;
          w_div_zero_next = r_is_div & r_bzero;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_div   <= 1'b0;
      r_hi       <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_bzero    <= 1'b0;
      r_a_raw    <= '0;
      r_mag_b    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_is_div   <= w_is_div_next;
      r_hi       <= w_hi_next;
      r_sign_a   <= w_sign_a_next;
      r_sign_b   <= w_sign_b_next;
      r_bzero    <= w_bzero_next;
      r_a_raw    <= w_a_raw_next;
      r_mag_b    <= w_mag_b_next;
      r_acc      <= w_acc_next;
      r_cnt      <= w_cnt_next;
      r_result   <= w_result_next;
      r_done     <= w_done_next;
      r_div_zero <= w_div_zero_next;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign result   = r_result;
  assign div_zero = r_div_zero;

endmodule
